// File: rtl/rr_arbiter32_pkg.sv
// Shared definitions for the 32-way round-robin arbiter.
package rr_arbiter32_pkg;
    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter32_decoder.sv
// Binary-to-one-hot decoders; the 5-to-32 is composed from a 2-to-4 and a 3-to-8.
module decoder2to4 (
    input  logic [1:0] a,
    output logic [3:0] d
);
    always_comb begin
        d    = '0;
        d[a] = 1'b1;
    end
endmodule

module decoder3to8 (
    input  logic [2:0] a,
    output logic [7:0] d
);
    always_comb begin
        d    = '0;
        d[a] = 1'b1;
    end
endmodule

module decoder5to32
    import rr_arbiter32_pkg::*;
(
    input  logic [IDX_W-1:0] a,
    output logic [N_REQ-1:0] d
);
    logic [3:0] d_hi;
    logic [7:0] d_lo;

    decoder2to4 u_hi (.a(a[4:3]), .d(d_hi));
    decoder3to8 u_lo (.a(a[2:0]), .d(d_lo));

    // Output h*8+l is the AND of row h and column l.
    for (genvar h = 0; h < 4; h++) begin : g_row
        for (genvar l = 0; l < 8; l++) begin : g_col
            assign d[h*8+l] = d_hi[h] & d_lo[l];
        end
    end
endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter for 32 requesters with grant hold, release and hold timeout.
module rr_arbiter32
    import rr_arbiter32_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic [N_REQ-1:0] dec_out;
    logic             req_any;
    logic             req_kept;
    logic             hold_hit;
    logic             release_now;

    // Scan from the highest offset down so the smallest offset from ptr wins.
    always_comb begin
        sel_idx = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                sel_idx = cand;
            end
        end
    end

    assign req_any     = |req;
    assign req_kept    = req[gnt_idx];
    assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign release_now = done || !req_kept || hold_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt_idx   <= sel_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        state     <= IDLE;
                        // Flag only a forced release; a voluntary one in the same cycle wins.
                        timeout   <= hold_hit && req_kept && !done;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    decoder5to32 u_dec (
        .a(gnt_idx),
        .d(dec_out)
    );

    assign gnt = dec_out & {N_REQ{gnt_valid}};
endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32 with a grant-index scoreboard.
module tb_rr_arbiter32;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        done;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    rr_arbiter32 #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_to);
        chk({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, "_gnt"}, gnt, 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    // Expected grantee is queued before the edge and compared once the grant appears.
    task automatic do_grant(input int idx);
        int e;
        exp_q.push_back(idx);
        step();
        chk("grant_valid", 32'(gnt_valid), 32'd1);
        e = exp_q.pop_front();
        chk("grant_idx", 32'(gnt_idx), 32'(e));
        chk("grant_onehot", gnt, 32'd1 << e);
        chk("grant_timeout", 32'(timeout), 32'd0);
    endtask

    task automatic release_done();
        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("rel_done", 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 32'hFFFF_FFFF;
        done = 1'b0;

        step();
        check_idle("reset1", 1'b0);
        step();
        check_idle("reset2", 1'b0);
        rst = 1'b0;
        do_grant(0);

        req = 32'h0;
        step();
        check_idle("first_drop", 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Rotation over requesters 0, 1 and 4.
        req = 32'h0000_0013;
        do_grant(0); step(); release_done();
        do_grant(1); step(); release_done();
        do_grant(4); step(); release_done();
        do_grant(0); step(); release_done();
        do_grant(1); step(); release_done();

        // Wrap from 31 back to 0.
        req = 32'h4000_0000;
        do_grant(30); release_done();
        req = 32'h8000_0001;
        do_grant(31); release_done();
        do_grant(0); release_done();

        // Hold timeout with MAX_HOLD=4.
        req = 32'h0000_0004;
        do_grant(2);
        step(); chk("hold1", 32'(gnt_valid), 32'd1);
        step(); chk("hold2", 32'(gnt_valid), 32'd1);
        step(); chk("hold3", 32'(gnt_valid), 32'd1);
        chk("hold3_timeout", 32'(timeout), 32'd0);
        step();
        check_idle("forced", 1'b1);
        do_grant(2);

        // Request drop releases without timeout.
        req = 32'h0000_0060;
        step();
        check_idle("drop2", 1'b0);
        do_grant(5);
        req = 32'h0000_0040;
        step();
        check_idle("drop5", 1'b0);
        do_grant(6);

        // Reset while granted.
        rst = 1'b1;
        step();
        check_idle("mid_rst", 1'b0);
        rst = 1'b0;
        req = 32'hFFFF_FFFF;
        do_grant(0);

        // done and request drop together give one release.
        done = 1'b1;
        req  = 32'hFFFF_FFFE;
        step();
        done = 1'b0;
        check_idle("both", 1'b0);
        do_grant(1);

        // done on the timeout cycle suppresses the timeout flag.
        step(); step(); step();
        chk("last_hold", 32'(gnt_valid), 32'd1);
        release_done();
        do_grant(2);

        // done while idle is ignored.
        req = 32'h0;
        step();
        check_idle("idle_pre", 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        check_idle("idle_done", 1'b0);
        req = 32'h0000_0008;
        do_grant(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
